instruction_fetch_sequencer: RTL and testbench

Read-side controller for the double-buffered instruction memory. Waits for an instruction block to become ready, then issues sequential read requests and absorbs the one-cycle read latency in a small show-ahead FIFO. Delivers instructions to the decoder with a valid/ready handshake, detects the end-of-block instruction, and drains. It then pulses the block-done strobe back to the memory so the buffer can be released and refilled.

---
 rtl/instruction_fetch_sequencer_if.sv | 40 ++++
 rtl/instruction_fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_sequencer_if.sv
// Instruction-memory read port and decoder delivery port of the fetch sequencer.
// master = sequencer side, slave = memory/decoder side.
interface instruction_fetch_sequencer_if #(
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 10
);
    logic                       imem_block_ready;
    logic                       imem_rd_req;
    logic [INST_ADDR_WIDTH-1:0] imem_rd_addr;
    logic                       imem_rd_valid;
    logic [INST_DATA_WIDTH-1:0] imem_rd_data;
    logic                       imem_rd_block_done;
    logic                       inst_valid;
    logic [INST_DATA_WIDTH-1:0] inst_data;
    logic                       inst_ready;

    modport master (
        input  imem_block_ready,
        output imem_rd_req,
        output imem_rd_addr,
        input  imem_rd_valid,
        input  imem_rd_data,
        output imem_rd_block_done,
        output inst_valid,
        output inst_data,
        input  inst_ready
    );

    modport slave (
        output imem_block_ready,
        input  imem_rd_req,
        input  imem_rd_addr,
        output imem_rd_valid,
        output imem_rd_data,
        input  imem_rd_block_done,
        input  inst_valid,
        input  inst_data,
        output inst_ready
    );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Sequential block reader: request -> FIFO push 1 cycle later -> inst_valid the cycle after.
// Decoder backpressure stalls requests via FIFO credits (fifo_count + inflight < FIFO_DEPTH).
module instruction_fetch_sequencer #(
    parameter int                  INST_DATA_WIDTH = 32,
    parameter int                  INST_ADDR_WIDTH = 10,
    parameter int                  FIFO_DEPTH      = 4,
    parameter int                  OPCODE_W        = 4,
    parameter logic [OPCODE_W-1:0] END_OPCODE      = {OPCODE_W{1'b1}}
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stop,
    instruction_fetch_sequencer_if.master      bus,
    output logic [15:0]                        block_count,
    output logic                               busy
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state;
    logic [INST_ADDR_WIDTH-1:0]  rd_addr;
    logic                        inflight;
    logic                        end_seen;
    logic                        last_issued;
    logic                        block_done_q;

    logic [INST_DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [PW:0]                 fifo_count;
    logic [PW:0]                 fifo_count_next;

    logic push;
    logic pop;
    logic end_now;
    logic end_any;
    logic credit_ok;

    assign push    = bus.imem_rd_valid && inflight;
    assign pop     = bus.inst_valid && bus.inst_ready;
    // The closing word (END opcode, or the return of the top address) stops
    // the request stream in the very cycle it arrives, so nothing past it is read.
    assign end_now = push && ((bus.imem_rd_data[INST_DATA_WIDTH-1 -: OPCODE_W] == END_OPCODE)
                              || last_issued);
    assign end_any = end_seen || end_now;

    assign credit_ok       = (fifo_count + (PW+1)'(inflight)) < (PW+1)'(FIFO_DEPTH);
    assign fifo_count_next = fifo_count + (PW+1)'(push) - (PW+1)'(pop);

    assign bus.imem_rd_req        = (state == S_FETCH) && !end_any && !last_issued && credit_ok;
    assign bus.imem_rd_addr       = rd_addr;
    assign bus.imem_rd_block_done = block_done_q;
    assign bus.inst_valid         = (fifo_count != '0);
    assign bus.inst_data          = fifo_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            block_done_q <= 1'b0;
            block_count  <= 16'd0;
            rd_addr      <= '0;
            inflight     <= 1'b0;
            end_seen     <= 1'b0;
            last_issued  <= 1'b0;
        end else begin
            inflight     <= bus.imem_rd_req;
            block_done_q <= 1'b0;
            if (bus.imem_rd_req) begin
                if (rd_addr == '1)
                    last_issued <= 1'b1;
                else
                    rd_addr <= rd_addr + INST_ADDR_WIDTH'(1);
            end
            if (end_now)
                end_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WAIT_BLK;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT_BLK: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (bus.imem_block_ready) begin
                        state   <= S_FETCH;
                        rd_addr <= '0;
                    end
                end
                S_FETCH: begin
                    if (end_any && !bus.imem_rd_req)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (fifo_count_next == '0) begin
                        state        <= S_DONE;
                        block_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state       <= S_WAIT_BLK;
                    block_count <= block_count + 16'd1;
                    end_seen    <= 1'b0;
                    last_issued <= 1'b0;
                    rd_addr     <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.imem_rd_data;
    end
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench: default-size sequencer plus a 3-bit-address instance for the top-address case.
module tb_instruction_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, stop_a, start_b, stop_b;
    logic [15:0] block_count_a, block_count_b;
    logic        busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    instruction_fetch_sequencer_if #(.INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(10)) if_a ();
    instruction_fetch_sequencer_if #(.INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(3))  if_b ();

    instruction_fetch_sequencer #(
        .INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(10), .FIFO_DEPTH(4),
        .OPCODE_W(4), .END_OPCODE(4'hF)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop_a),
        .bus(if_a.master), .block_count(block_count_a), .busy(busy_a)
    );

    instruction_fetch_sequencer #(
        .INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(3), .FIFO_DEPTH(4),
        .OPCODE_W(4), .END_OPCODE(4'hF)
    ) u_small (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b),
        .bus(if_b.master), .block_count(block_count_b), .busy(busy_b)
    );

    // Memory models: capture the request mid-cycle, answer during the following cycle.
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [8];
    logic        cap_req_a, cap_req_b;
    logic [9:0]  cap_addr_a;
    logic [2:0]  cap_addr_b;
    bit          spur_a;

    always begin
        @(negedge clk);
        cap_req_a  = if_a.imem_rd_req;
        cap_addr_a = if_a.imem_rd_addr;
        @(posedge clk);
        #2;
        if_a.imem_rd_valid = cap_req_a || spur_a;
        if_a.imem_rd_data  = cap_req_a ? mem_a[cap_addr_a] : 32'hDEAD_BEEF;
    end

    always begin
        @(negedge clk);
        cap_req_b  = if_b.imem_rd_req;
        cap_addr_b = if_b.imem_rd_addr;
        @(posedge clk);
        #2;
        if_b.imem_rd_valid = cap_req_b;
        if_b.imem_rd_data  = cap_req_b ? mem_b[cap_addr_b] : 32'hDEAD_BEEF;
    end

    // Observation of requests, deliveries and done pulses.
    logic [9:0]  reqa_q[$];
    logic [31:0] outa_q[$];
    logic [2:0]  reqb_q[$];
    logic [31:0] outb_q[$];
    int          done_a = 0, done_b = 0, max_cnt_a = 0;

    always @(negedge clk) begin
        if (if_a.imem_rd_req === 1'b1) reqa_q.push_back(if_a.imem_rd_addr);
        if (if_a.inst_valid === 1'b1 && if_a.inst_ready === 1'b1) outa_q.push_back(if_a.inst_data);
        if (if_a.imem_rd_block_done === 1'b1) done_a++;
        if (if_b.imem_rd_req === 1'b1) reqb_q.push_back(if_b.imem_rd_addr);
        if (if_b.inst_valid === 1'b1 && if_b.inst_ready === 1'b1) outb_q.push_back(if_b.inst_data);
        if (if_b.imem_rd_block_done === 1'b1) done_b++;
        if (int'(u_dut.fifo_count) > max_cnt_a) max_cnt_a = int'(u_dut.fifo_count);
        if (if_a.imem_rd_valid === 1'b1 && u_dut.inflight === 1'b1 && u_dut.fifo_count == 3'd4) begin
            fails++;
            $error("FAIL overflow: push into full FIFO, count %0d required below 4", u_dut.fifo_count);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done_a(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (if_a.imem_rd_block_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic clear_obs();
        reqa_q.delete(); outa_q.delete(); reqb_q.delete(); outb_q.delete();
        done_a = 0; done_b = 0; max_cnt_a = 0;
    endtask

    initial begin
        bit seen;
        reset = 1'b1; start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0; spur_a = 1'b0;
        if_a.imem_block_ready = 1'b0; if_a.inst_ready = 1'b0;
        if_b.imem_block_ready = 1'b0; if_b.inst_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem_b[i] = {4'h5, 28'h500 + 28'(i)};

        // Reset state
        tick(3);
        chk("rst_req", if_a.imem_rd_req, 1'b0);
        chk("rst_addr", if_a.imem_rd_addr, 10'd0);
        chk("rst_done", if_a.imem_rd_block_done, 1'b0);
        chk("rst_valid", if_a.inst_valid, 1'b0);
        chk("rst_count", block_count_a, 16'd0);
        chk("rst_busy", busy_a, 1'b0);
        reset = 1'b0;
        tick(1);

        // Basic block: 5 words, END at word 4
        for (int i = 0; i < 5; i++) mem_a[i] = {4'h1, 28'h100 + 28'(i)};
        mem_a[4] = 32'hF000_0104;
        mem_a[5] = 32'h1000_0105;
        if_a.inst_ready = 1'b1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("start_busy", busy_a, 1'b1);
        clear_obs();
        if_a.imem_block_ready = 1'b1;
        chk("wait_no_req", if_a.imem_rd_req, 1'b0);
        tick(1);
        if_a.imem_block_ready = 1'b0;
        chk("basic_first_req", if_a.imem_rd_req, 1'b1);
        chk("basic_first_addr", if_a.imem_rd_addr, 10'd0);
        tick(1);
        chk("basic_valid_t2", if_a.inst_valid, 1'b0);
        tick(1);
        chk("basic_valid_t3", if_a.inst_valid, 1'b1);
        chk("basic_data_t3", if_a.inst_data, 32'h1000_0100);
        tick(4);
        chk("basic_done_t7", if_a.imem_rd_block_done, 1'b0);
        tick(1);
        chk("basic_done_t8", if_a.imem_rd_block_done, 1'b1);
        tick(1);
        chk("basic_done_t9", if_a.imem_rd_block_done, 1'b0);
        chk("basic_count", block_count_a, 16'd1);
        chk("basic_nreq", reqa_q.size(), 5);
        chk("basic_nout", outa_q.size(), 5);
        chk("basic_ndone", done_a, 1);
        for (int i = 0; i < 5; i++) chk("basic_addr", reqa_q[i], i);
        chk("basic_w0", outa_q[0], 32'h1000_0100);
        chk("basic_w3", outa_q[3], 32'h1000_0103);
        chk("basic_w4", outa_q[4], 32'hF000_0104);

        // Backpressure: 12 words, decoder stalls 10 cycles
        for (int i = 0; i < 12; i++) mem_a[i] = {4'h2, 28'h200 + 28'(i)};
        mem_a[11] = 32'hF000_020B;
        clear_obs();
        if_a.imem_block_ready = 1'b1;
        tick(1);
        if_a.imem_block_ready = 1'b0;
        tick(3);
        if_a.inst_ready = 1'b0;
        tick(6);
        chk("bp_stall_req", if_a.imem_rd_req, 1'b0);
        chk("bp_stall_valid", if_a.inst_valid, 1'b1);
        chk("bp_stall_head", if_a.inst_data, 32'h2000_0201);
        tick(4);
        if_a.inst_ready = 1'b1;
        chk("bp_max_fill", max_cnt_a, 4);
        chk("bp_resume_req0", if_a.imem_rd_req, 1'b0);
        tick(1);
        chk("bp_resume_req1", if_a.imem_rd_req, 1'b1);
        chk("bp_resume_addr", if_a.imem_rd_addr, 10'd5);
        wait_done_a(40, seen);
        chk("bp_done_seen", seen, 1'b1);
        tick(1);
        chk("bp_count", block_count_a, 16'd2);
        chk("bp_nreq", reqa_q.size(), 12);
        chk("bp_nout", outa_q.size(), 12);
        for (int i = 0; i < 12; i++) chk("bp_addr", reqa_q[i], i);
        for (int i = 0; i < 11; i++) chk("bp_word", outa_q[i], {4'h2, 28'h200 + 28'(i)});
        chk("bp_last", outa_q[11], 32'hF000_020B);

        // Back-to-back: two 3-word blocks with block_ready held
        for (int i = 0; i < 3; i++) mem_a[i] = {4'h3, 28'h300 + 28'(i)};
        mem_a[2] = 32'hF000_0302;
        clear_obs();
        if_a.imem_block_ready = 1'b1;
        tick(6);
        chk("b2b_done1", if_a.imem_rd_block_done, 1'b1);
        tick(2);
        chk("b2b_req2", if_a.imem_rd_req, 1'b1);
        chk("b2b_addr2", if_a.imem_rd_addr, 10'd0);
        tick(5);
        chk("b2b_done2", if_a.imem_rd_block_done, 1'b1);
        if_a.imem_block_ready = 1'b0;
        tick(2);
        chk("b2b_idle_req", if_a.imem_rd_req, 1'b0);
        chk("b2b_busy", busy_a, 1'b1);
        chk("b2b_count", block_count_a, 16'd4);
        chk("b2b_ndone", done_a, 2);
        chk("b2b_nreq", reqa_q.size(), 6);
        chk("b2b_nout", outa_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("b2b_addr", reqa_q[i], i % 3);
        chk("b2b_w5", outa_q[5], 32'hF000_0302);

        // Spurious valid with nothing in flight, start while busy
        spur_a = 1'b1;
        start_a = 1'b1;
        tick(1);
        spur_a = 1'b0;
        start_a = 1'b0;
        tick(1);
        chk("spur_fifo", u_dut.fifo_count, 3'd0);
        chk("spur_valid", if_a.inst_valid, 1'b0);
        chk("spur_busy", busy_a, 1'b1);
        chk("spur_req", if_a.imem_rd_req, 1'b0);
        chk("spur_count", block_count_a, 16'd4);

        // Async reset during DRAIN with 2 entries queued
        mem_a[0] = 32'h4000_0400;
        mem_a[1] = 32'hF000_0401;
        if_a.inst_ready = 1'b0;
        if_a.imem_block_ready = 1'b1;
        tick(1);
        if_a.imem_block_ready = 1'b0;
        tick(3);
        chk("drain_fill", u_dut.fifo_count, 3'd2);
        chk("drain_valid", if_a.inst_valid, 1'b1);
        chk("drain_req", if_a.imem_rd_req, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", if_a.imem_rd_req, 1'b0);
        chk("arst_addr", if_a.imem_rd_addr, 10'd0);
        chk("arst_done", if_a.imem_rd_block_done, 1'b0);
        chk("arst_valid", if_a.inst_valid, 1'b0);
        chk("arst_count", block_count_a, 16'd0);
        chk("arst_busy", busy_a, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // stop in WAIT_BLK wins over block_ready
        if_a.inst_ready = 1'b1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("stop_pre_busy", busy_a, 1'b1);
        stop_a = 1'b1;
        if_a.imem_block_ready = 1'b1;
        tick(1);
        stop_a = 1'b0;
        if_a.imem_block_ready = 1'b0;
        chk("stop_busy", busy_a, 1'b0);
        tick(1);
        chk("stop_req", if_a.imem_rd_req, 1'b0);
        chk("stop_count", block_count_a, 16'd0);

        // Top-address boundary on the 3-bit instance, no END opcode
        if_b.inst_ready = 1'b1;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        clear_obs();
        if_b.imem_block_ready = 1'b1;
        tick(1);
        if_b.imem_block_ready = 1'b0;
        chk("bnd_req0", if_b.imem_rd_req, 1'b1);
        chk("bnd_addr0", if_b.imem_rd_addr, 3'd0);
        tick(7);
        chk("bnd_req7", if_b.imem_rd_req, 1'b1);
        chk("bnd_addr7", if_b.imem_rd_addr, 3'd7);
        tick(1);
        chk("bnd_req_after", if_b.imem_rd_req, 1'b0);
        chk("bnd_addr_hold", if_b.imem_rd_addr, 3'd7);
        tick(1);
        chk("bnd_done_t10", if_b.imem_rd_block_done, 1'b0);
        tick(1);
        chk("bnd_done_t11", if_b.imem_rd_block_done, 1'b1);
        tick(1);
        chk("bnd_count", block_count_b, 16'd1);
        chk("bnd_ndone", done_b, 1);
        chk("bnd_nreq", reqb_q.size(), 8);
        chk("bnd_nout", outb_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("bnd_addr", reqb_q[i], i);
        for (int i = 0; i < 8; i++) chk("bnd_word", outb_q[i], {4'h5, 28'h500 + 28'(i)});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
